lcd_bus_responder: RTL

LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

---
 rtl/lcd_bus_responder_if.sv | 36 +++
 rtl/lcd_bus_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder_if.sv
`default_nettype none
// ============================================================================
// lcd_bus_responder_if : HD44780 write bus plus responder status/read port
// Revision: 1.0
// ============================================================================
interface lcd_bus_responder_if;
   logic [7:0] LCD_DATA_BIT;
   logic       LCD_ENABLE;
   logic       LCD_REGISTER_SELECT;
   logic       LCD_READ_WRITE;
   logic       CHAR_VALID;
   logic [7:0] CHAR_DATA;
   logic [6:0] CHAR_ADDR;
   logic       CMD_VALID;
   logic [7:0] CMD_CODE;
   logic [6:0] RD_INDEX;
   logic [7:0] RD_DATA;
   logic [5:0] DISPLAY_OFFSET;
   logic       DISPLAY_ON;
   logic       BUSY;
   logic [3:0] ERR_FLAGS;
   logic [7:0] LED;

   modport master (
      output LCD_DATA_BIT, LCD_ENABLE, LCD_REGISTER_SELECT, LCD_READ_WRITE, RD_INDEX,
      input  CHAR_VALID, CHAR_DATA, CHAR_ADDR, CMD_VALID, CMD_CODE, RD_DATA,
             DISPLAY_OFFSET, DISPLAY_ON, BUSY, ERR_FLAGS, LED
   );

   modport slave (
      input  LCD_DATA_BIT, LCD_ENABLE, LCD_REGISTER_SELECT, LCD_READ_WRITE, RD_INDEX,
      output CHAR_VALID, CHAR_DATA, CHAR_ADDR, CMD_VALID, CMD_CODE, RD_DATA,
             DISPLAY_OFFSET, DISPLAY_ON, BUSY, ERR_FLAGS, LED
   );
endinterface
`default_nettype wire

// File: rtl/lcd_bus_responder.sv
`default_nettype none
// ============================================================================
// lcd_bus_responder : passive HD44780 model that decodes writes into a shadow
// DDRAM, tracks cursor/shift state and reports protocol errors.
// Revision: 1.0
// ============================================================================
module lcd_bus_responder #(
   parameter int E_MIN_HIGH = 10,
   parameter int CMD_BUSY   = 1850,
   parameter int CLEAR_BUSY = 76000,
   parameter int LINE_LEN   = 40
) (
   input wire logic          CLOCK_50MHZ,
   input wire logic          BUTTON_SOUTH,
   lcd_bus_responder_if.slave bus
);
   localparam int         c_FILL_LEN   = 2 * LINE_LEN;
   localparam int         c_BUSY_MAX   = (CLEAR_BUSY > CMD_BUSY) ? CLEAR_BUSY : CMD_BUSY;
   localparam int         c_BUSY_W     = $clog2(c_BUSY_MAX + 1);
   localparam logic [5:0] c_LAST_COL   = 6'(LINE_LEN - 1);
   localparam logic [1:0] c_ST_IDLE    = 2'd0;
   localparam logic [1:0] c_ST_FILL    = 2'd1;
   localparam logic [1:0] c_ST_CLRWAIT = 2'd2;

   function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
      logic [6:0] r;
      if (up) begin
         if (a == {1'b0, c_LAST_COL})      r = 7'h40;
         else if (a == {1'b1, c_LAST_COL}) r = 7'h00;
         else                              r = a + 7'd1;
      end else begin
         if (a == 7'h00)      r = {1'b1, c_LAST_COL};
         else if (a == 7'h40) r = {1'b0, c_LAST_COL};
         else                 r = a - 7'd1;
      end
      return r;
   endfunction

   function automatic logic [5:0] offset_step(input logic [5:0] o, input logic up);
      logic [5:0] r;
      if (up) r = (o == c_LAST_COL) ? 6'd0 : o + 6'd1;
      else    r = (o == 6'd0) ? c_LAST_COL : o - 6'd1;
      return r;
   endfunction

   function automatic logic [6:0] shadow_index(input logic [6:0] a);
      return a[6] ? (7'(LINE_LEN) + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
   endfunction

   logic [7:0]          data_s1_q, data_s2_q;
   logic                e_s1_q, e_s2_q, e_prev_q;
   logic                rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
   logic [15:0]         e_cnt_q, e_cnt_d;
   logic                stb_q, stb_d, stb_rs_q, stb_rs_d;
   logic [7:0]          stb_byte_q, stb_byte_d;
   logic [6:0]          addr_q, addr_d;
   logic                id_q, id_d, s_q, s_d;
   logic [5:0]          offset_q, offset_d;
   logic                disp_on_q, disp_on_d;
   logic [1:0]          state_q, state_d;
   logic [6:0]          fill_idx_q, fill_idx_d;
   logic [c_BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
   logic                busy_start_q, busy_start_d;
   logic                char_valid_q, char_valid_d, cmd_valid_q, cmd_valid_d;
   logic [7:0]          char_data_q, char_data_d, cmd_code_q, cmd_code_d;
   logic [6:0]          char_addr_q, char_addr_d;
   logic [3:0]          err_q, err_d;
   logic                char_seen_q, char_seen_d, cmd_seen_q, cmd_seen_d;
   logic [7:0]          led_q, led_d, rd_data_q, rd_data_d;

   logic [7:0]          shadow_mem [c_FILL_LEN];
   logic                w_e_fall, w_busy, w_busy_any, w_wr_en;
   logic [6:0]          w_wr_idx;
   logic [7:0]          w_wr_data;

   assign w_e_fall   = e_prev_q & ~e_s2_q;
   assign w_busy     = (state_q != c_ST_IDLE) || (busy_cnt_q != '0);
   // A strobe accepted in the previous two cycles has not raised BUSY yet.
   assign w_busy_any = w_busy | busy_start_q | stb_q;

   always_comb begin
      e_cnt_d      = e_s2_q ? ((e_cnt_q == 16'hFFFF) ? e_cnt_q : e_cnt_q + 16'd1) : 16'd0;
      stb_d        = 1'b0;
      stb_rs_d     = stb_rs_q;
      stb_byte_d   = stb_byte_q;
      addr_d       = addr_q;
      id_d         = id_q;
      s_d          = s_q;
      offset_d     = offset_q;
      disp_on_d    = disp_on_q;
      state_d      = state_q;
      fill_idx_d   = fill_idx_q;
      busy_cnt_d   = busy_cnt_q;
      busy_start_d = 1'b0;
      char_valid_d = 1'b0;
      cmd_valid_d  = 1'b0;
      char_data_d  = char_data_q;
      char_addr_d  = char_addr_q;
      cmd_code_d   = cmd_code_q;
      err_d        = err_q;
      char_seen_d  = char_seen_q | char_valid_q;
      cmd_seen_d   = cmd_seen_q | cmd_valid_q;
      w_wr_en      = 1'b0;
      w_wr_idx     = 7'd0;
      w_wr_data    = 8'h00;

      if (w_e_fall) begin
         if (e_cnt_q < 16'(E_MIN_HIGH)) err_d[0] = 1'b1;
         else if (rw_s2_q)              err_d[3] = 1'b1;
         else if (w_busy_any)           err_d[1] = 1'b1;
         else begin
            stb_d      = 1'b1;
            stb_rs_d   = rs_s2_q;
            stb_byte_d = data_s2_q;
         end
      end

      case (state_q)
         c_ST_IDLE: begin
            if (busy_start_q)            busy_cnt_d = c_BUSY_W'(CMD_BUSY);
            else if (busy_cnt_q != '0)   busy_cnt_d = busy_cnt_q - c_BUSY_W'(1);
         end
         c_ST_FILL: begin
            w_wr_en   = 1'b1;
            w_wr_idx  = fill_idx_q;
            w_wr_data = 8'h20;
            if (fill_idx_q == 7'(c_FILL_LEN - 1)) begin
               state_d    = c_ST_CLRWAIT;
               busy_cnt_d = c_BUSY_W'(CLEAR_BUSY - 1);
            end else begin
               fill_idx_d = fill_idx_q + 7'd1;
            end
         end
         c_ST_CLRWAIT: begin
            if (busy_cnt_q == '0) state_d = c_ST_IDLE;
            else                  busy_cnt_d = busy_cnt_q - c_BUSY_W'(1);
         end
         default: state_d = c_ST_IDLE;
      endcase

      if (stb_q) begin
         busy_start_d = 1'b1;
         if (stb_rs_q) begin
            char_valid_d = 1'b1;
            char_data_d  = stb_byte_q;
            char_addr_d  = addr_q;
            w_wr_en      = 1'b1;
            w_wr_idx     = shadow_index(addr_q);
            w_wr_data    = stb_byte_q;
            addr_d       = addr_step(addr_q, id_q);
            if (s_q) offset_d = offset_step(offset_q, id_q);
         end else begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = stb_byte_q;
            casez (stb_byte_q)
               8'b1???????: begin
                  if (stb_byte_q[5:0] > c_LAST_COL) err_d[2] = 1'b1;
                  else                              addr_d   = stb_byte_q[6:0];
               end
               8'b01??????, 8'b001?????: begin
               end
               8'b0001????: begin
                  if (stb_byte_q[3]) offset_d = offset_step(offset_q, ~stb_byte_q[2]);
                  else               addr_d   = addr_step(addr_q, stb_byte_q[2]);
               end
               8'b00001???: disp_on_d = stb_byte_q[2];
               8'b000001??: begin
                  id_d = stb_byte_q[1];
                  s_d  = stb_byte_q[0];
               end
               8'b0000001?: begin
                  addr_d   = 7'd0;
                  offset_d = 6'd0;
               end
               8'b00000001: begin
                  addr_d       = 7'd0;
                  offset_d     = 6'd0;
                  id_d         = 1'b1;
                  state_d      = c_ST_FILL;
                  fill_idx_d   = 7'd0;
                  busy_start_d = 1'b0;
               end
               default: begin
               end
            endcase
         end
      end

      rd_data_d = (bus.RD_INDEX < 7'(c_FILL_LEN)) ? shadow_mem[bus.RD_INDEX] : 8'h00;
      led_d     = {err_q, w_busy, disp_on_q, char_seen_q, cmd_seen_q};
   end

   always_ff @(posedge CLOCK_50MHZ) begin
      if (BUTTON_SOUTH) begin
         data_s1_q <= 8'h00;  data_s2_q <= 8'h00;
         e_s1_q    <= 1'b0;   e_s2_q    <= 1'b0;   e_prev_q <= 1'b0;
         rs_s1_q   <= 1'b0;   rs_s2_q   <= 1'b0;
         rw_s1_q   <= 1'b0;   rw_s2_q   <= 1'b0;
         e_cnt_q   <= 16'd0;
         stb_q     <= 1'b0;   stb_rs_q  <= 1'b0;   stb_byte_q <= 8'h00;
         addr_q    <= 7'd0;   id_q      <= 1'b1;   s_q        <= 1'b0;
         offset_q  <= 6'd0;   disp_on_q <= 1'b0;
         state_q   <= c_ST_IDLE;
         fill_idx_q   <= 7'd0;
         busy_cnt_q   <= '0;
         busy_start_q <= 1'b0;
         char_valid_q <= 1'b0; char_data_q <= 8'h00; char_addr_q <= 7'd0;
         cmd_valid_q  <= 1'b0; cmd_code_q  <= 8'h00;
         err_q        <= 4'd0;
         char_seen_q  <= 1'b0; cmd_seen_q  <= 1'b0;
         led_q        <= 8'h00; rd_data_q  <= 8'h00;
      end else begin
         data_s1_q <= bus.LCD_DATA_BIT;        data_s2_q <= data_s1_q;
         e_s1_q    <= bus.LCD_ENABLE;          e_s2_q    <= e_s1_q;   e_prev_q <= e_s2_q;
         rs_s1_q   <= bus.LCD_REGISTER_SELECT; rs_s2_q   <= rs_s1_q;
         rw_s1_q   <= bus.LCD_READ_WRITE;      rw_s2_q   <= rw_s1_q;
         e_cnt_q   <= e_cnt_d;
         stb_q     <= stb_d;   stb_rs_q  <= stb_rs_d;  stb_byte_q <= stb_byte_d;
         addr_q    <= addr_d;  id_q      <= id_d;      s_q        <= s_d;
         offset_q  <= offset_d; disp_on_q <= disp_on_d;
         state_q   <= state_d;
         fill_idx_q   <= fill_idx_d;
         busy_cnt_q   <= busy_cnt_d;
         busy_start_q <= busy_start_d;
         char_valid_q <= char_valid_d; char_data_q <= char_data_d; char_addr_q <= char_addr_d;
         cmd_valid_q  <= cmd_valid_d;  cmd_code_q  <= cmd_code_d;
         err_q        <= err_d;
         char_seen_q  <= char_seen_d;  cmd_seen_q  <= cmd_seen_d;
         led_q        <= led_d;        rd_data_q   <= rd_data_d;
      end
   end

   // Shadow contents are deliberately not reset; only a clear defines them.
   always_ff @(posedge CLOCK_50MHZ) begin
      if (w_wr_en && !BUTTON_SOUTH) shadow_mem[w_wr_idx] <= w_wr_data;
   end

   assign bus.CHAR_VALID     = char_valid_q;
   assign bus.CHAR_DATA      = char_data_q;
   assign bus.CHAR_ADDR      = char_addr_q;
   assign bus.CMD_VALID      = cmd_valid_q;
   assign bus.CMD_CODE       = cmd_code_q;
   assign bus.RD_DATA        = rd_data_q;
   assign bus.DISPLAY_OFFSET = offset_q;
   assign bus.DISPLAY_ON     = disp_on_q;
   assign bus.BUSY           = w_busy;
   assign bus.ERR_FLAGS      = err_q;
   assign bus.LED            = led_q;
endmodule
`default_nettype wire
